// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter onto a single-outstanding memory port
// Fetch (0) and load/store (1) share one memory port; a single transaction is tracked IDLE -> ISSUE -> WAIT.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*DATA_W/8-1:0]   req_wstrb,
  output logic [1:0]              resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_wstrb,
  input  logic                    mem_rvalid,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rr_last;
  logic                r_owner;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic [1:0]          r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                w_grant;
  logic                w_accept;

  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_rr_last;
      default: w_grant = 1'b0;
    endcase
  end

  // Gating with reset keeps req_ready low for the whole time reset is held.
  assign w_accept  = (r_state == S_IDLE) && (req_valid != 2'b00) && !reset;
  assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_ISSUE;
      S_ISSUE: if (mem_ready)  w_next = S_WAIT;
      S_WAIT:  if (mem_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last    <= 1'b1;
      r_owner      <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 2'b00;
      if (w_accept) begin
        r_rr_last   <= w_grant;
        r_owner     <= w_grant;
        r_mem_valid <= 1'b1;
        r_mem_addr  <= w_grant ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
        r_mem_wdata <= w_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        r_mem_wstrb <= w_grant ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
      end
      if (r_state == S_ISSUE && mem_ready) r_mem_valid <= 1'b0;
      if (r_state == S_WAIT && mem_rvalid) begin
        r_resp_rdata <= mem_rdata;
        r_resp_valid <= r_owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign mem_valid  = r_mem_valid;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wstrb  = r_mem_wstrb;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid; bit 0 is fetch, bit 1 is load/store.
REQ-006 req_ready  output  2  per-requester accept; a request transfers on req_valid[i] && req_ready[i].
REQ-007 req_addr  input  2*ADDR_W  per-requester address; slice i is [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  input  2*DATA_W  per-requester write data.
REQ-009 req_wstrb  input  2*DATA_W/8  per-requester byte strobes; all-zero means read.
REQ-010 resp_valid  output  2  per-requester one-cycle response pulse.
REQ-011 resp_rdata  output  DATA_W  response data shared by both requesters, qualified by resp_valid.
REQ-012 mem_valid  output  1  memory request valid.
REQ-013 mem_ready  input  1  memory accepts the request when mem_valid && mem_ready.
REQ-014 mem_addr, mem_wdata, mem_wstrb  output  ADDR_W, DATA_W, DATA_W/8  registered request fields.
REQ-015 mem_rvalid  input  1  memory completion, for both reads and writes.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid with mem_rvalid.

Function
REQ-017 The block SHALL implement three states: IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-018 In IDLE, req_ready SHALL be combinational and one-hot-or-zero: set only for the granted requester, and only when that requester's req_valid is high.
REQ-019 Grant with one requester valid: that requester, regardless of the round-robin pointer.
REQ-020 Grant with both requesters valid: the requester not recorded in register rr_last.
REQ-021 rr_last SHALL update to the granted index on the accept cycle.
REQ-022 On accept, the block SHALL latch the requester's addr, wdata and wstrb into the mem_* registers, record the owner, set mem_valid=1 and go to ISSUE.
REQ-023 In ISSUE, mem_valid and all mem_* fields SHALL be held stable until mem_ready.
- On mem_ready: mem_valid goes to 0 next edge; state goes to WAIT.
REQ-024 In WAIT, on mem_rvalid, the block SHALL register resp_rdata=mem_rdata and pulse resp_valid[owner] for exactly one cycle, then return to IDLE.
REQ-025 req_ready SHALL be 0 in ISSUE and WAIT.
REQ-026 mem_rvalid outside WAIT SHALL be ignored.
REQ-027 mem_ready outside ISSUE SHALL be ignored.
REQ-028 Latency, accept at edge N:
- mem_valid visible in cycle N+1;
- with mem_ready in N+1 and mem_rvalid in N+2, resp_valid is high in cycle N+3;
- next accept is possible in cycle N+3.
REQ-029 Requesters hold their request fields stable while req_valid && !req_ready; the block SHALL never drop or reorder accepted requests.
REQ-030 resp_rdata SHALL hold its last value when resp_valid is 0; for writes its value is don't-care.

Reset
REQ-031 On reset assertion, asynchronously and regardless of clk:
- state=IDLE, rr_last=1, owner=0;
- mem_valid=0, resp_valid=0;
- mem_addr, mem_wdata, mem_wstrb and resp_rdata = 0.
REQ-032 req_ready SHALL be 0 while reset is high.
REQ-033 An in-flight transaction interrupted by reset SHALL be abandoned; a late mem_rvalid after reset SHALL produce no resp_valid.

Verification
REQ-034 Reset: assert reset mid-cycle -> mem_valid=0, resp_valid=0 and req_ready=0 immediately, without a clock edge.
REQ-035 Fetch read 0x100, mem_ready=1, mem_rvalid next cycle with 0xDEADBEEF:
- req_ready=2'b01 for one cycle;
- mem_addr=0x100, mem_wstrb=0;
- resp_valid=2'b01 for one cycle with resp_rdata=0xDEADBEEF.
REQ-036 Both requesters valid after reset, held continuously -> grants in order 0, 1, 0, 1; never two consecutive grants to the same requester.
REQ-037 mem_ready held low 5 cycles in ISSUE -> mem_valid=1 and mem_addr/wdata/wstrb unchanged for all 5 cycles; req_ready=0 throughout.
REQ-038 Load/store write 0x200, wdata 0x12345678, wstrb 0xF -> mem_wstrb=0xF, mem_wdata=0x12345678; on mem_rvalid, resp_valid=2'b10 for one cycle.
REQ-039 Reset pulse in WAIT, then mem_rvalid=1 -> no resp_valid; the next req_valid[1] is accepted from IDLE (rr_last=1 and a single valid requester).
